// File: rtl/dx_tri_bus_ctrl_if.sv
// Command/response and IO-buffer signals of the half-duplex bus sequencer.
// master = the sequencer itself, slave = front end plus IO buffer side.
interface dx_tri_bus_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_wr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  bus_stb;
  logic [DATA_WIDTH-1:0] dio_i;
  logic [DATA_WIDTH-1:0] dio_t;
  logic [DATA_WIDTH-1:0] dio_o;

  modport master (
    input  cmd_valid, cmd_wr, cmd_wdata, dio_o,
    output cmd_ready, rsp_valid, rsp_data, bus_stb, dio_i, dio_t
  );

  modport slave (
    output cmd_valid, cmd_wr, cmd_wdata, dio_o,
    input  cmd_ready, rsp_valid, rsp_data, bus_stb, dio_i, dio_t
  );
endinterface

// File: rtl/dx_tri_bus_ctrl.sv
// Half-duplex bus sequencer: turns write/read commands into single-cycle bus
// transfers with released turnaround cycles on every direction change.
//
//   state | meaning
//   IDLE  | bus released, waiting for a command
//   TURN  | bus released for TA_CYCLES cycles before a direction change
//   XFER  | one bus transfer cycle, bus_stb high
module dx_tri_bus_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int TA_CYCLES  = 1
) (
  input  logic               clk,
  input  logic               rst,
  dx_tri_bus_ctrl_if.master  bus
);

  typedef enum logic [1:0] {IDLE, TURN, XFER} state_t;

  localparam logic [DATA_WIDTH-1:0] ALL_Z   = '1;
  localparam logic [3:0]            TA_LOAD = 4'(TA_CYCLES - 1);

  state_t                state;
  logic [3:0]            cnt;
  logic                  cur_wr;
  logic [DATA_WIDTH-1:0] cur_data;
  logic                  last_wr;
  logic                  last_valid;

  logic                  accept;
  logic                  go_turn;
  logic                  launch;
  logic                  l_wr;
  logic [DATA_WIDTH-1:0] l_data;

  assign accept  = bus.cmd_valid && bus.cmd_ready;
  // last_wr already reflects the transfer in flight while in XFER
  assign go_turn = last_valid && (bus.cmd_wr != last_wr) && (TA_CYCLES != 0);
  assign launch  = (state == TURN) ? (cnt == 4'd0) : (accept && !go_turn);
  assign l_wr    = (state == TURN) ? cur_wr   : bus.cmd_wr;
  assign l_data  = (state == TURN) ? cur_data : bus.cmd_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      cur_wr        <= 1'b0;
      cur_data      <= '0;
      last_wr       <= 1'b0;
      last_valid    <= 1'b0;
      bus.cmd_ready <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
      bus.bus_stb   <= 1'b0;
      bus.dio_i     <= '0;
      bus.dio_t     <= ALL_Z;
    end else begin
      bus.rsp_valid <= 1'b0;
      if (state == XFER && !cur_wr) begin
        bus.rsp_valid <= 1'b1;
        bus.rsp_data  <= bus.dio_o;
      end

      if (state != TURN && accept) begin
        cur_wr   <= bus.cmd_wr;
        cur_data <= bus.cmd_wdata;
      end

      if (launch) begin
        state         <= XFER;
        bus.bus_stb   <= 1'b1;
        bus.dio_t     <= l_wr ? '0 : ALL_Z;
        if (l_wr) bus.dio_i <= l_data;
        bus.cmd_ready <= 1'b1;
        last_wr       <= l_wr;
        last_valid    <= 1'b1;
      end else if (state == TURN) begin
        cnt <= cnt - 4'd1;
      end else if (accept) begin
        state         <= TURN;
        cnt           <= TA_LOAD;
        bus.cmd_ready <= 1'b0;
        bus.bus_stb   <= 1'b0;
        bus.dio_t     <= ALL_Z;
      end else begin
        state         <= IDLE;
        bus.cmd_ready <= 1'b1;
        bus.bus_stb   <= 1'b0;
        bus.dio_t     <= ALL_Z;
      end
    end
  end

endmodule

// File: tb/tb_dx_tri_bus_ctrl.sv
// Directed bench: dut_a uses a 1-cycle turnaround, dut_b a 2-cycle turnaround.
// The far end of each bus is a simple IO-buffer model driven by far_a/far_b.
module tb_dx_tri_bus_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic [7:0] far_a, far_b;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dx_tri_bus_ctrl_if #(.DATA_WIDTH(8)) bus_a ();
  dx_tri_bus_ctrl_if #(.DATA_WIDTH(8)) bus_b ();

  assign bus_a.dio_o = bus_a.dio_t[0] ? far_a : bus_a.dio_i;
  assign bus_b.dio_o = bus_b.dio_t[0] ? far_b : bus_b.dio_i;

  dx_tri_bus_ctrl #(.DATA_WIDTH(8), .TA_CYCLES(1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  dx_tri_bus_ctrl #(.DATA_WIDTH(8), .TA_CYCLES(2)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_cmp++;
    if ({bus_a.cmd_ready, bus_a.rsp_valid, bus_a.rsp_data, bus_a.bus_stb, bus_a.dio_t, bus_a.dio_i} !== {1'b0, 1'b0, 8'h00, 1'b0, 8'hFF, 8'h00}) begin
      n_err++;
      $display("FAIL reset_a: got rdy=%b rv=%b rd=%h stb=%b t=%h i=%h", bus_a.cmd_ready, bus_a.rsp_valid, bus_a.rsp_data, bus_a.bus_stb, bus_a.dio_t, bus_a.dio_i);
    end
    n_cmp++;
    if ({bus_b.cmd_ready, bus_b.rsp_valid, bus_b.rsp_data, bus_b.bus_stb, bus_b.dio_t, bus_b.dio_i} !== {1'b0, 1'b0, 8'h00, 1'b0, 8'hFF, 8'h00}) begin
      n_err++;
      $display("FAIL reset_b: got rdy=%b rv=%b rd=%h stb=%b t=%h i=%h", bus_b.cmd_ready, bus_b.rsp_valid, bus_b.rsp_data, bus_b.bus_stb, bus_b.dio_t, bus_b.dio_i);
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if ({bus_a.cmd_ready, bus_b.cmd_ready} !== 2'b11) begin
      n_err++;
      $display("FAIL ready_after_reset: got a=%b b=%b want 1 1", bus_a.cmd_ready, bus_b.cmd_ready);
    end
  endtask

  task automatic test_write();
    bus_a.cmd_valid = 1'b1; bus_a.cmd_wr = 1'b1; bus_a.cmd_wdata = 8'hA5;
    tick();
    bus_a.cmd_valid = 1'b0;
    n_cmp++;
    if ({bus_a.bus_stb, bus_a.dio_t, bus_a.dio_i, bus_a.cmd_ready} !== {1'b1, 8'h00, 8'hA5, 1'b1}) begin
      n_err++;
      $display("FAIL write_xfer: got stb=%b t=%h i=%h rdy=%b want 1 00 a5 1", bus_a.bus_stb, bus_a.dio_t, bus_a.dio_i, bus_a.cmd_ready);
    end
    tick();
    n_cmp++;
    if ({bus_a.bus_stb, bus_a.dio_t, bus_a.dio_i} !== {1'b0, 8'hFF, 8'hA5}) begin
      n_err++;
      $display("FAIL write_release: got stb=%b t=%h i=%h want 0 ff a5", bus_a.bus_stb, bus_a.dio_t, bus_a.dio_i);
    end
  endtask

  task automatic test_back_to_back();
    bus_a.cmd_valid = 1'b1; bus_a.cmd_wr = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      bus_a.cmd_wdata = 8'(k);
      tick();
      n_cmp++;
      if ({bus_a.bus_stb, bus_a.dio_t, bus_a.dio_i, bus_a.cmd_ready} !== {1'b1, 8'h00, 8'(k), 1'b1}) begin
        n_err++;
        $display("FAIL b2b_write_%0d: got stb=%b t=%h i=%h rdy=%b want 1 00 %h 1", k, bus_a.bus_stb, bus_a.dio_t, bus_a.dio_i, bus_a.cmd_ready, 8'(k));
      end
    end
    bus_a.cmd_valid = 1'b0;
    tick();
    n_cmp++;
    if ({bus_a.bus_stb, bus_a.dio_t, bus_a.dio_i} !== {1'b0, 8'hFF, 8'h04}) begin
      n_err++;
      $display("FAIL b2b_idle: got stb=%b t=%h i=%h want 0 ff 04", bus_a.bus_stb, bus_a.dio_t, bus_a.dio_i);
    end
  endtask

  task automatic test_read_first();
    far_b = 8'hEE;
    bus_b.cmd_valid = 1'b1; bus_b.cmd_wr = 1'b0;
    tick();
    bus_b.cmd_valid = 1'b0;
    far_b = 8'h3C;
    n_cmp++;
    if ({bus_b.bus_stb, bus_b.dio_t, bus_b.rsp_valid} !== {1'b1, 8'hFF, 1'b0}) begin
      n_err++;
      $display("FAIL read_xfer: got stb=%b t=%h rv=%b want 1 ff 0", bus_b.bus_stb, bus_b.dio_t, bus_b.rsp_valid);
    end
    tick();
    far_b = 8'h00;
    n_cmp++;
    if ({bus_b.rsp_valid, bus_b.rsp_data, bus_b.bus_stb} !== {1'b1, 8'h3C, 1'b0}) begin
      n_err++;
      $display("FAIL read_rsp: got rv=%b rd=%h stb=%b want 1 3c 0", bus_b.rsp_valid, bus_b.rsp_data, bus_b.bus_stb);
    end
    tick();
    n_cmp++;
    if (bus_b.rsp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL read_rsp_width: got rv=%b want 0", bus_b.rsp_valid);
    end
  endtask

  task automatic test_wr_to_rd_ta2();
    bus_b.cmd_valid = 1'b1; bus_b.cmd_wr = 1'b1; bus_b.cmd_wdata = 8'h11;
    tick();
    bus_b.cmd_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      n_cmp++;
      if ({bus_b.cmd_ready, bus_b.bus_stb, bus_b.dio_t} !== {1'b0, 1'b0, 8'hFF}) begin
        n_err++;
        $display("FAIL ta2_rd_to_wr_turn_%0d: got rdy=%b stb=%b t=%h want 0 0 ff", c, bus_b.cmd_ready, bus_b.bus_stb, bus_b.dio_t);
      end
      tick();
    end
    n_cmp++;
    if ({bus_b.bus_stb, bus_b.dio_t, bus_b.dio_i, bus_b.cmd_ready} !== {1'b1, 8'h00, 8'h11, 1'b1}) begin
      n_err++;
      $display("FAIL ta2_write_xfer: got stb=%b t=%h i=%h rdy=%b want 1 00 11 1", bus_b.bus_stb, bus_b.dio_t, bus_b.dio_i, bus_b.cmd_ready);
    end
    bus_b.cmd_valid = 1'b1; bus_b.cmd_wr = 1'b0;
    tick();
    bus_b.cmd_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      n_cmp++;
      if ({bus_b.cmd_ready, bus_b.bus_stb, bus_b.dio_t} !== {1'b0, 1'b0, 8'hFF}) begin
        n_err++;
        $display("FAIL ta2_wr_to_rd_turn_%0d: got rdy=%b stb=%b t=%h want 0 0 ff", c, bus_b.cmd_ready, bus_b.bus_stb, bus_b.dio_t);
      end
      if (c == 1) far_b = 8'hC3;
      tick();
    end
    n_cmp++;
    if ({bus_b.bus_stb, bus_b.dio_t, bus_b.cmd_ready, bus_b.rsp_valid} !== {1'b1, 8'hFF, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL ta2_read_xfer: got stb=%b t=%h rdy=%b rv=%b want 1 ff 1 0", bus_b.bus_stb, bus_b.dio_t, bus_b.cmd_ready, bus_b.rsp_valid);
    end
    tick();
    far_b = 8'h00;
    n_cmp++;
    if ({bus_b.rsp_valid, bus_b.rsp_data} !== {1'b1, 8'hC3}) begin
      n_err++;
      $display("FAIL ta2_read_rsp: got rv=%b rd=%h want 1 c3", bus_b.rsp_valid, bus_b.rsp_data);
    end
  endtask

  task automatic test_rd_to_wr();
    far_a = 8'h3C;
    bus_a.cmd_valid = 1'b1; bus_a.cmd_wr = 1'b0;
    tick();
    bus_a.cmd_valid = 1'b0;
    n_cmp++;
    if ({bus_a.cmd_ready, bus_a.bus_stb, bus_a.dio_t} !== {1'b0, 1'b0, 8'hFF}) begin
      n_err++;
      $display("FAIL rw_turn_before_read: got rdy=%b stb=%b t=%h want 0 0 ff", bus_a.cmd_ready, bus_a.bus_stb, bus_a.dio_t);
    end
    tick();
    n_cmp++;
    if ({bus_a.bus_stb, bus_a.dio_t, bus_a.cmd_ready} !== {1'b1, 8'hFF, 1'b1}) begin
      n_err++;
      $display("FAIL rw_read_xfer: got stb=%b t=%h rdy=%b want 1 ff 1", bus_a.bus_stb, bus_a.dio_t, bus_a.cmd_ready);
    end
    bus_a.cmd_valid = 1'b1; bus_a.cmd_wr = 1'b1; bus_a.cmd_wdata = 8'h5A;
    tick();
    bus_a.cmd_valid = 1'b0;
    n_cmp++;
    if ({bus_a.bus_stb, bus_a.dio_t, bus_a.dio_i, bus_a.cmd_ready, bus_a.rsp_valid, bus_a.rsp_data} !== {1'b0, 8'hFF, 8'h04, 1'b0, 1'b1, 8'h3C}) begin
      n_err++;
      $display("FAIL rw_released_cycle: got stb=%b t=%h i=%h rdy=%b rv=%b rd=%h want 0 ff 04 0 1 3c", bus_a.bus_stb, bus_a.dio_t, bus_a.dio_i, bus_a.cmd_ready, bus_a.rsp_valid, bus_a.rsp_data);
    end
    tick();
    n_cmp++;
    if ({bus_a.bus_stb, bus_a.dio_t, bus_a.dio_i, bus_a.dio_o} !== {1'b1, 8'h00, 8'h5A, 8'h5A}) begin
      n_err++;
      $display("FAIL rw_write_xfer: got stb=%b t=%h i=%h o=%h want 1 00 5a 5a", bus_a.bus_stb, bus_a.dio_t, bus_a.dio_i, bus_a.dio_o);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    far_a = 8'h99;
    bus_a.cmd_valid = 1'b1; bus_a.cmd_wr = 1'b0;
    tick();
    bus_a.cmd_valid = 1'b0;
    n_cmp++;
    if ({bus_a.cmd_ready, bus_a.bus_stb} !== 2'b00) begin
      n_err++;
      $display("FAIL rst_mid_turn: got rdy=%b stb=%b want 0 0", bus_a.cmd_ready, bus_a.bus_stb);
    end
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_cmp++;
      if ({bus_a.rsp_valid, bus_a.bus_stb, bus_a.dio_t, bus_a.cmd_ready} !== {1'b0, 1'b0, 8'hFF, 1'b0}) begin
        n_err++;
        $display("FAIL rst_mid_drop_%0d: got rv=%b stb=%b t=%h rdy=%b want 0 0 ff 0", c, bus_a.rsp_valid, bus_a.bus_stb, bus_a.dio_t, bus_a.cmd_ready);
      end
    end
    rst = 1'b0;
    tick();
    bus_a.cmd_valid = 1'b1; bus_a.cmd_wr = 1'b1; bus_a.cmd_wdata = 8'h77;
    tick();
    bus_a.cmd_valid = 1'b0;
    n_cmp++;
    if ({bus_a.bus_stb, bus_a.dio_t, bus_a.dio_i, bus_a.rsp_valid} !== {1'b1, 8'h00, 8'h77, 1'b0}) begin
      n_err++;
      $display("FAIL rst_mid_post_write: got stb=%b t=%h i=%h rv=%b want 1 00 77 0", bus_a.bus_stb, bus_a.dio_t, bus_a.dio_i, bus_a.rsp_valid);
    end
    tick();
  endtask

  initial begin
    rst = 1'b1;
    far_a = 8'h00; far_b = 8'h00;
    bus_a.cmd_valid = 1'b0; bus_a.cmd_wr = 1'b0; bus_a.cmd_wdata = 8'h00;
    bus_b.cmd_valid = 1'b0; bus_b.cmd_wr = 1'b0; bus_b.cmd_wdata = 8'h00;
    test_reset();
    test_write();
    test_back_to_back();
    test_read_first();
    test_wr_to_rd_ta2();
    test_rd_to_wr();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
